// File: rtl/pipe_pkg.sv
// Shared types and constants for the CPU inter-stage pipeline registers.
package pipe_pkg;

  localparam int FLUSH_PHASE_W   = 3;
  localparam int MAX_FLUSH_DEPTH = 8;

  typedef logic [FLUSH_PHASE_W-1:0] flush_phase_t;

  // Bit positions of the forwarding fields packed into the ctrl word
  localparam int CTRL_FWD_XX_A   = 0;
  localparam int CTRL_FWD_XX_B   = 1;
  localparam int CTRL_FWD_XM_A   = 2;
  localparam int CTRL_FWD_XM_B   = 3;
  localparam int CTRL_XX_SEL_LSB = 4;
  localparam int CTRL_XX_SEL_W   = 2;
  localparam int CTRL_XM_SEL_LSB = 6;
  localparam int CTRL_XM_SEL_W   = 2;

  function automatic flush_phase_t last_flush_phase(input int depth);
    return flush_phase_t'(depth - 1);
  endfunction

endpackage

// File: rtl/pipe_dff.sv
// Codebase D flip-flop cell with asynchronous active-low reset to zero.
module pipe_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_flush_seq.sv
// Flush sequencer: pending-flush flag, phase counter and flush_active for one pipeline register.
module pipe_flush_seq
  import pipe_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  output logic         feff,
  output logic         flush_active,
  output flush_phase_t flush_phase,
  output logic         flush_pend
);

  localparam flush_phase_t LAST_PHASE = last_flush_phase(FLUSH_DEPTH);

  logic         pend_d, pend_q;
  logic         active_d, active_q;
  flush_phase_t phase_d, phase_q;

  assign feff = (flush | pend_q) & ~stall;

  // Next-state: stall captures a flush, effective flush restarts at phase 0
  always_comb begin
    pend_d   = pend_q;
    active_d = active_q;
    phase_d  = phase_q;
    if (stall) begin
      if (flush) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end else if (feff) begin
      pend_d   = 1'b0;
      active_d = 1'b1;
      phase_d  = {FLUSH_PHASE_W{1'b0}};
    end else if (active_q) begin
      if (phase_q == LAST_PHASE) begin
        active_d = 1'b0;
        phase_d  = {FLUSH_PHASE_W{1'b0}};
      end else begin
        phase_d  = flush_phase_t'(phase_q + 3'd1);
      end
    end else begin
      active_d = 1'b0;
      phase_d  = {FLUSH_PHASE_W{1'b0}};
    end
  end

  pipe_dff #(.W(1)) u_pend_ff (.clk(clk), .rst_n(rst_n), .d(pend_d), .q(pend_q));
  pipe_dff #(.W(1)) u_active_ff (.clk(clk), .rst_n(rst_n), .d(active_d), .q(active_q));
  pipe_dff #(.W(FLUSH_PHASE_W)) u_phase_ff (.clk(clk), .rst_n(rst_n), .d(phase_d), .q(phase_q));

  assign flush_active = active_q;
  assign flush_phase  = phase_q;
  assign flush_pend   = pend_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall-hold, flush-kill and flush sequencing.
// Optional bubble counter output enabled by defining PIPE_BUBBLE_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CTRL_W      = 8,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              flush_active,
  output flush_phase_t      flush_phase,
  output logic              flush_pend
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  logic              feff;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  pipe_flush_seq #(.FLUSH_DEPTH(FLUSH_DEPTH)) u_flush_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .feff         (feff),
    .flush_active (flush_active),
    .flush_phase  (flush_phase),
    .flush_pend   (flush_pend)
  );

  // Slot muxes: hold on stall, kill valid/ctrl on flush while the payload still advances
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (stall) begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
    end else if (feff) begin
      valid_d = 1'b0;
      data_d  = in_data;
      ctrl_d  = {CTRL_W{1'b0}};
    end else begin
      valid_d = in_valid;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end
  end

  pipe_dff #(.W(1)) u_valid_ff (.clk(clk), .rst_n(rst_n), .d(valid_d), .q(valid_q));
  pipe_dff #(.W(DATA_W)) u_data_ff (.clk(clk), .rst_n(rst_n), .d(data_d), .q(data_q));
  pipe_dff #(.W(CTRL_W)) u_ctrl_ff (.clk(clk), .rst_n(rst_n), .d(ctrl_d), .q(ctrl_q));

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

`ifdef PIPE_BUBBLE_CNT_EN
  logic [15:0] bubble_d, bubble_q;

  // Saturating count of unstalled cycles presenting an empty slot
  always_comb begin
    bubble_d = bubble_q;
    if (!stall && !valid_q && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end else begin
      bubble_d = bubble_q;
    end
  end

  pipe_dff #(.W(16)) u_bubble_ff (.clk(clk), .rst_n(rst_n), .d(bubble_d), .q(bubble_q));

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (DATA_W=16, CTRL_W=8, FLUSH_DEPTH=3).
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid, flush_active, flush_pend;
  logic [15:0] out_data;
  logic [7:0]  out_ctrl;
  logic [2:0]  flush_phase;
`ifdef PIPE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  typedef struct packed {
    logic        ov;
    logic [15:0] od;
    logic [7:0]  oc;
    logic        fa;
    logic [2:0]  fp;
    logic        pd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .FLUSH_DEPTH(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .flush_active (flush_active),
    .flush_phase  (flush_phase),
    .flush_pend   (flush_pend)
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    .bubble_cnt   (bubble_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: after every edge, compare the outputs against the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("out_valid", int'(out_valid), int'(e.ov));
      chk("out_data", int'(out_data), int'(e.od));
      chk("out_ctrl", int'(out_ctrl), int'(e.oc));
      chk("flush_active", int'(flush_active), int'(e.fa));
      chk("flush_phase", int'(flush_phase), int'(e.fp));
      chk("flush_pend", int'(flush_pend), int'(e.pd));
    end
  end

  task automatic step(input logic r, input logic s, input logic f, input logic iv,
                      input logic [15:0] d, input logic [7:0] c,
                      input logic eov, input logic [15:0] eod, input logic [7:0] eoc,
                      input logic efa, input logic [2:0] efp, input logic epd);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    stall    = s;
    flush    = f;
    in_valid = iv;
    in_data  = d;
    in_ctrl  = c;
    e.ov = eov; e.od = eod; e.oc = eoc; e.fa = efa; e.fp = efp; e.pd = epd;
    sb_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = 16'h0000; in_ctrl = 8'h00;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h5A, 1'b0, 16'h0000, 8'h00, 1'b0, 3'd0, 1'b0);
    // pass-through, 4 cycles
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h5A, 1'b1, 16'h1234, 8'h5A, 1'b0, 3'd0, 1'b0);
    // stall hold
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 8'h3C, 1'b1, 16'hBEEF, 8'h3C, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 8'hFF, 1'b1, 16'hBEEF, 8'h3C, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 8'hFF, 1'b1, 16'hBEEF, 8'h3C, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 8'hFF, 1'b1, 16'hBEEF, 8'h3C, 1'b0, 3'd0, 1'b0);
    // flush sequence: phases 0,1,2 then inactive
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'hA5A5, 8'hFF, 1'b0, 16'hA5A5, 8'h00, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 8'h11, 1'b1, 16'h0001, 8'h11, 1'b1, 3'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 8'h12, 1'b1, 16'h0002, 8'h12, 1'b1, 3'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 8'h13, 1'b1, 16'h0003, 8'h13, 1'b0, 3'd0, 1'b0);
    // flush during stall, second flush absorbed, applied on release
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h7777, 8'h77, 1'b1, 16'h0003, 8'h13, 1'b0, 3'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h8888, 8'h88, 1'b1, 16'h0003, 8'h13, 1'b0, 3'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h9999, 8'h99, 1'b0, 16'h9999, 8'h00, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h000A, 8'h0A, 1'b1, 16'h000A, 8'h0A, 1'b1, 3'd1, 1'b0);
    // restart at phase 1, then a 2-cycle stall freezes phase 1
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 8'h0B, 1'b0, 16'h000B, 8'h00, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h000C, 8'h0C, 1'b1, 16'h000C, 8'h0C, 1'b1, 3'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000D, 8'h0D, 1'b1, 16'h000C, 8'h0C, 1'b1, 3'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000D, 8'h0D, 1'b1, 16'h000C, 8'h0C, 1'b1, 3'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h000E, 8'h0E, 1'b1, 16'h000E, 8'h0E, 1'b1, 3'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h000F, 8'h0F, 1'b1, 16'h000F, 8'h0F, 1'b0, 3'd0, 1'b0);
    // start a sequence, then reset asynchronously mid-sequence
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h1357, 8'h88, 1'b0, 16'h1357, 8'h00, 1'b1, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h2468, 8'h44, 1'b1, 16'h2468, 8'h44, 1'b1, 3'd1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_out_data", int'(out_data), 0);
    chk("async_out_ctrl", int'(out_ctrl), 0);
    chk("async_flush_active", int'(flush_active), 0);
    chk("async_flush_phase", int'(flush_phase), 0);
    chk("async_flush_pend", int'(flush_pend), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 3'd0, 1'b0);
    // five unstalled bubble cycles after reset release
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
`ifdef PIPE_BUBBLE_CNT_EN
    chk("bubble_cnt", int'(bubble_cnt), 5);
`endif
    stall = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
